// File: rtl/systolic_array_4x4_pkg.sv
// Shared definitions for the 4x4 weight-stationary systolic array.
// Default datapath width and per-PE mode encodings.
package systolic_array_4x4_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int ARRAY_DIM          = 4;

    typedef enum logic {
        MODE_COMPUTE = 1'b0,
        MODE_LOAD    = 1'b1
    } pe_mode_e;

endpackage

// File: rtl/systolic_array_4x4_pe.sv
// One multiply-accumulate cell: stationary weight, activation passes
// right, partial sum passes down. Load mode turns the column into a shift chain.
module systolic_pe
    import systolic_array_4x4_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  pe_mode_e              mode,
    input  logic                  left_en,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic                  up_en,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  d_en,
    output logic [DATA_WIDTH-1:0] d_data
);

    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] mac;

    // Low DATA_WIDTH bits of a two's complement product/sum are sign-agnostic
    assign prod = w * left_data;
    assign mac  = up_data + prod;

    // Weight shift in load mode, single-cycle MAC in compute mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w      <= '0;
            r_en   <= 1'b0;
            r_data <= '0;
            d_en   <= 1'b0;
            d_data <= '0;
        end else if (mode == MODE_LOAD) begin
            r_en <= 1'b0;
            if (up_en) begin
                w      <= up_data;
                d_data <= up_data;
                d_en   <= 1'b1;
            end else begin
                d_en <= 1'b0;
            end
        end else if (left_en) begin
            d_data <= mac;
            d_en   <= 1'b1;
            r_data <= left_data;
            r_en   <= 1'b1;
        end else begin
            d_data <= up_data;
            d_en   <= 1'b0;
            r_data <= '0;
            r_en   <= 1'b0;
        end
    end

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 mesh of MAC cells; activations enter left, sums leave the bottom.
// Column j streams row j of A*B where the stored weights are A transposed.
module systolic_array_4x4
    import systolic_array_4x4_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  array_clk,
    input  logic                  array_rst_n,
    input  logic                  array_en_left_0_0,
    input  logic                  array_en_left_1_0,
    input  logic                  array_en_left_2_0,
    input  logic                  array_en_left_3_0,
    input  logic [DATA_WIDTH-1:0] array_data_left_0_0,
    input  logic [DATA_WIDTH-1:0] array_data_left_1_0,
    input  logic [DATA_WIDTH-1:0] array_data_left_2_0,
    input  logic [DATA_WIDTH-1:0] array_data_left_3_0,
    input  logic                  array_en_up_0_0,
    input  logic                  array_en_up_0_1,
    input  logic                  array_en_up_0_2,
    input  logic                  array_en_up_0_3,
    input  logic [DATA_WIDTH-1:0] array_data_up_0_0,
    input  logic [DATA_WIDTH-1:0] array_data_up_0_1,
    input  logic [DATA_WIDTH-1:0] array_data_up_0_2,
    input  logic [DATA_WIDTH-1:0] array_data_up_0_3,
    output logic                  array_en_down_3_0,
    output logic                  array_en_down_3_1,
    output logic                  array_en_down_3_2,
    output logic                  array_en_down_3_3,
    output logic [DATA_WIDTH-1:0] array_data_down_3_0,
    output logic [DATA_WIDTH-1:0] array_data_down_3_1,
    output logic [DATA_WIDTH-1:0] array_data_down_3_2,
    output logic [DATA_WIDTH-1:0] array_data_down_3_3,
    input  logic                  array_mode_0_0,
    input  logic                  array_mode_0_1,
    input  logic                  array_mode_0_2,
    input  logic                  array_mode_0_3,
    input  logic                  array_mode_1_0,
    input  logic                  array_mode_1_1,
    input  logic                  array_mode_1_2,
    input  logic                  array_mode_1_3,
    input  logic                  array_mode_2_0,
    input  logic                  array_mode_2_1,
    input  logic                  array_mode_2_2,
    input  logic                  array_mode_2_3,
    input  logic                  array_mode_3_0,
    input  logic                  array_mode_3_1,
    input  logic                  array_mode_3_2,
    input  logic                  array_mode_3_3
);

    localparam int N = ARRAY_DIM;

    logic [N-1:0]          left_en;
    logic [N-1:0]          up_en;
    logic [DATA_WIDTH-1:0] left_data [N];
    logic [DATA_WIDTH-1:0] up_data   [N];
    logic [N-1:0]          mode_row  [N];

    logic                  h_en   [N][N];
    logic [DATA_WIDTH-1:0] h_data [N][N];
    logic                  v_en   [N][N];
    logic [DATA_WIDTH-1:0] v_data [N][N];
    logic                  r_en   [N][N];
    logic [DATA_WIDTH-1:0] r_data [N][N];
    logic                  d_en   [N][N];
    logic [DATA_WIDTH-1:0] d_data [N][N];

    assign left_en = {array_en_left_3_0, array_en_left_2_0,
                      array_en_left_1_0, array_en_left_0_0};
    assign up_en   = {array_en_up_0_3, array_en_up_0_2,
                      array_en_up_0_1, array_en_up_0_0};

    assign left_data = '{array_data_left_0_0, array_data_left_1_0,
                         array_data_left_2_0, array_data_left_3_0};
    assign up_data   = '{array_data_up_0_0, array_data_up_0_1,
                         array_data_up_0_2, array_data_up_0_3};

    assign mode_row[0] = {array_mode_0_3, array_mode_0_2,
                          array_mode_0_1, array_mode_0_0};
    assign mode_row[1] = {array_mode_1_3, array_mode_1_2,
                          array_mode_1_1, array_mode_1_0};
    assign mode_row[2] = {array_mode_2_3, array_mode_2_2,
                          array_mode_2_1, array_mode_2_0};
    assign mode_row[3] = {array_mode_3_3, array_mode_3_2,
                          array_mode_3_1, array_mode_3_0};

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_edge_l
                assign h_en[i][j]   = left_en[i];
                assign h_data[i][j] = left_data[i];
            end else begin : g_mesh_h
                assign h_en[i][j]   = r_en[i][j-1];
                assign h_data[i][j] = r_data[i][j-1];
            end

            if (i == 0) begin : g_edge_u
                assign v_en[i][j]   = up_en[j];
                assign v_data[i][j] = up_data[j];
            end else begin : g_mesh_v
                assign v_en[i][j]   = d_en[i-1][j];
                assign v_data[i][j] = d_data[i-1][j];
            end

            systolic_pe #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_pe (
                .clk      (array_clk),
                .rst_n    (array_rst_n),
                .mode     (pe_mode_e'(mode_row[i][j])),
                .left_en  (h_en[i][j]),
                .left_data(h_data[i][j]),
                .up_en    (v_en[i][j]),
                .up_data  (v_data[i][j]),
                .r_en     (r_en[i][j]),
                .r_data   (r_data[i][j]),
                .d_en     (d_en[i][j]),
                .d_data   (d_data[i][j])
            );
        end
    end

    assign array_en_down_3_0   = d_en[N-1][0];
    assign array_en_down_3_1   = d_en[N-1][1];
    assign array_en_down_3_2   = d_en[N-1][2];
    assign array_en_down_3_3   = d_en[N-1][3];
    assign array_data_down_3_0 = d_data[N-1][0];
    assign array_data_down_3_1 = d_data[N-1][1];
    assign array_data_down_3_2 = d_data[N-1][2];
    assign array_data_down_3_3 = d_data[N-1][3];

    // Right-edge horizontal outputs leave the array unconnected
    wire unused_right = ^{r_en[0][N-1], r_data[0][N-1],
                          r_en[1][N-1], r_data[1][N-1],
                          r_en[2][N-1], r_data[2][N-1],
                          r_en[3][N-1], r_data[3][N-1]};

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Scoreboard bench for the 4x4 systolic array.
// Expected bottom values and their arrival edge are queued per column.
module tb_systolic_array_4x4;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        int            edge_n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    en_left;
    logic [3:0]    en_up;
    logic [3:0]    en_down;
    logic [DW-1:0] data_left [4];
    logic [DW-1:0] data_up   [4];
    logic [DW-1:0] data_down [4];
    logic [3:0]    mode      [4];

    exp_t sbq [4][$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   W [4][4];
    int   B [4][8];
    int   A [4][4] = '{'{-1, 2, 3, 4}, '{5, -6, 7, 8},
                       '{9, -10, 11, 12}, '{13, 14, 15, -16}};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_4x4 #(.DATA_WIDTH(DW)) dut (
        .array_clk          (clk),
        .array_rst_n        (rst_n),
        .array_en_left_0_0  (en_left[0]),
        .array_en_left_1_0  (en_left[1]),
        .array_en_left_2_0  (en_left[2]),
        .array_en_left_3_0  (en_left[3]),
        .array_data_left_0_0(data_left[0]),
        .array_data_left_1_0(data_left[1]),
        .array_data_left_2_0(data_left[2]),
        .array_data_left_3_0(data_left[3]),
        .array_en_up_0_0    (en_up[0]),
        .array_en_up_0_1    (en_up[1]),
        .array_en_up_0_2    (en_up[2]),
        .array_en_up_0_3    (en_up[3]),
        .array_data_up_0_0  (data_up[0]),
        .array_data_up_0_1  (data_up[1]),
        .array_data_up_0_2  (data_up[2]),
        .array_data_up_0_3  (data_up[3]),
        .array_en_down_3_0  (en_down[0]),
        .array_en_down_3_1  (en_down[1]),
        .array_en_down_3_2  (en_down[2]),
        .array_en_down_3_3  (en_down[3]),
        .array_data_down_3_0(data_down[0]),
        .array_data_down_3_1(data_down[1]),
        .array_data_down_3_2(data_down[2]),
        .array_data_down_3_3(data_down[3]),
        .array_mode_0_0     (mode[0][0]),
        .array_mode_0_1     (mode[0][1]),
        .array_mode_0_2     (mode[0][2]),
        .array_mode_0_3     (mode[0][3]),
        .array_mode_1_0     (mode[1][0]),
        .array_mode_1_1     (mode[1][1]),
        .array_mode_1_2     (mode[1][2]),
        .array_mode_1_3     (mode[1][3]),
        .array_mode_2_0     (mode[2][0]),
        .array_mode_2_1     (mode[2][1]),
        .array_mode_2_2     (mode[2][2]),
        .array_mode_2_3     (mode[2][3]),
        .array_mode_3_0     (mode[3][0]),
        .array_mode_3_1     (mode[3][1]),
        .array_mode_3_2     (mode[3][2]),
        .array_mode_3_3     (mode[3][3])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_inputs();
        en_left = '0;
        en_up   = '0;
        for (int i = 0; i < 4; i++) begin
            data_left[i] = '0;
            data_up[i]   = '0;
            mode[i]      = '0;
        end
    endtask

    // Shift W into the array; the first value presented exits at the 4th edge
    task automatic load_weights();
        int c0;
        exp_t e;
        c0 = cyc;
        for (int i = 0; i < 4; i++) mode[i] = '1;
        for (int j = 0; j < 4; j++) begin
            e.data   = W[3][j];
            e.edge_n = c0 + 4;
            sbq[j].push_back(e);
        end
        for (int s = 0; s < 4; s++) begin
            en_up = '1;
            for (int j = 0; j < 4; j++) data_up[j] = W[3-s][j];
            tick();
        end
        clear_inputs();
    endtask

    // Drive B skewed by row; column j result k lands at edge c0+4+j+k
    task automatic compute(input int k_cnt);
        int c0;
        longint acc;
        exp_t e;
        c0 = cyc;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < k_cnt; k++) begin
                acc = 0;
                for (int i = 0; i < 4; i++)
                    acc += longint'(W[i][j]) * longint'(B[i][k]);
                e.data   = acc[DW-1:0];
                e.edge_n = c0 + 4 + j + k;
                sbq[j].push_back(e);
            end
        end
        for (int t = 0; t < k_cnt + 3; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (t - i >= 0 && t - i < k_cnt) begin
                    en_left[i]   = 1'b1;
                    data_left[i] = B[i][t-i];
                end else begin
                    en_left[i]   = 1'b0;
                    data_left[i] = '0;
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic set_w_at();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                W[i][j] = A[j][i];
    endtask

    task automatic set_b_ref();
        int bref [4][3] = '{'{1, -2, 3}, '{4, 5, 6},
                            '{7, 8, 9}, '{10, -11, 12}};
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++)
                B[i][k] = (k < 3) ? bref[i][k] : 0;
    endtask

    // Pop the scoreboard on every valid bottom output, flag late or stray ones
    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < 4; j++) begin
                if (en_down[j]) begin
                    if (sbq[j].size() == 0) begin
                        check($sformatf("col%0d stray en", j), 1, 0);
                    end else begin
                        mon_e = sbq[j].pop_front();
                        check($sformatf("col%0d data", j),
                              data_down[j], mon_e.data);
                        check($sformatf("col%0d edge", j),
                              cyc, mon_e.edge_n);
                    end
                end else if (sbq[j].size() > 0 &&
                             sbq[j][0].edge_n <= cyc) begin
                    mon_e = sbq[j].pop_front();
                    check($sformatf("col%0d missing", j), 0, 1);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rb [7] = '{4, 3, 2, 1, 0, 0, 0};
        exp_t e;
        int left;

        clear_inputs();
        rst_n   = 1'b0;
        en_left = 4'($urandom);
        en_up   = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            data_left[i] = $urandom;
            data_up[i]   = $urandom;
            mode[i]      = 4'($urandom);
        end
        repeat (3) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                check($sformatf("rst en%0d", j), en_down[j], 0);
                check($sformatf("rst data%0d", j), data_down[j], 0);
            end
        end
        clear_inputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                check($sformatf("idle data%0d", j), data_down[j], 0);
        end
        tick();

        // Column 0 shift chain readback: 4,3,2,1 on successive edges
        begin
            int c0;
            c0 = cyc;
            for (int i = 0; i < 4; i++) mode[i] = '1;
            for (int s = 0; s < 7; s++) begin
                en_up[0]   = 1'b1;
                data_up[0] = rb[s];
                if (s < 4) begin
                    e.data   = rb[s];
                    e.edge_n = c0 + 4 + s;
                    sbq[0].push_back(e);
                end
                tick();
            end
            clear_inputs();
            idle(6);
        end

        // Reference matmul, en_left drops right after the last element
        set_w_at();
        load_weights();
        idle(2);
        set_b_ref();
        compute(3);
        idle(12);

        // Wrap-around: 0x7FFFFFFF * 2 -> 0xFFFFFFFE
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                W[i][j] = 0;
        W[0][0] = 32'h7FFF_FFFF;
        load_weights();
        idle(2);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++)
                B[i][k] = 0;
        B[0][0] = 2;
        compute(1);
        idle(10);

        // Reload with identity weights: outputs reproduce B
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                W[i][j] = (i == j) ? 1 : 0;
        load_weights();
        idle(2);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++)
                B[i][k] = int'($urandom);
        compute(6);
        idle(14);

        // Mid-operation reset wipes the weights
        set_w_at();
        load_weights();
        idle(8);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                W[i][j] = 0;
        tick();
        set_b_ref();
        compute(3);
        idle(12);

        left = 0;
        for (int j = 0; j < 4; j++) left += sbq[j].size();
        check("drain", left, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
